// File: rtl/game_pkg.sv
// Shared types and constants for the pinball game flow controller.
// The BCD helper is also used by the hex display path.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_BALL_LOST = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  localparam logic [7:0] BCD_MAX = 8'h99;

  localparam int DEF_LIVES        = 3;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_LOST_FRAMES  = 90;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_MAX)          r = v;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD counter with synchronous clear (priority) and enable,
// saturating at 99.
module bcd_counter_2d
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = '0;
    else if (en_i) q_d = bcd_inc_sat(q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/game_sequencer.sv
// Pinball game flow: serve / play / ball-lost / game-over sequencing,
// per-frame hit and drain detection, BCD score and lives.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES        = DEF_LIVES,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int LOST_FRAMES  = DEF_LOST_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       collisionSmileyFlipper,
  input  logic       ballLost,
  input  logic       launchIsPressed,
  output logic [2:0] gameState,
  output logic       motionEnable,
  output logic       ballRespawn,
  output logic [7:0] scoreBcd,
  output logic [1:0] livesLeft,
  output logic       gameOver
);

  localparam int CNT_MAX = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] LOST_LAST  = CW'(LOST_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  game_state_t   state_q, state_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]    lives_q, lives_d;
  logic          hit_f_q, lost_f_q, hit_prev_q;
  logic          launch_prev_q, launch_armed_q;
  logic          motion_q, respawn_q, respawn_d, game_over_q;
  logic          hit_now, lost_now, new_hit, press, score_inc, score_clr;

  assign hit_now  = hit_f_q | collisionSmileyFlipper;
  assign lost_now = lost_f_q | ballLost;
  assign new_hit  = hit_now & ~hit_prev_q;
  // A key already held when reset releases must be let go before it counts.
  assign press    = launchIsPressed & ~launch_prev_q & launch_armed_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = startOfFrame ? frame_cnt_q + 1'b1 : frame_cnt_q;
    lives_d     = lives_q;
    respawn_d   = 1'b0;
    score_inc   = 1'b0;
    score_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lives_d   = LIVES_INIT;
        score_clr = 1'b1;
        if (press) begin
          state_d   = ST_SERVE;
          respawn_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (startOfFrame && frame_cnt_q == SERVE_LAST) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (startOfFrame) begin
          if (lost_now) begin
            lives_d = lives_q - 2'd1;
            state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_BALL_LOST;
          end else if (new_hit) begin
            score_inc = 1'b1;
          end
        end
      end
      ST_BALL_LOST: begin
        if (startOfFrame && frame_cnt_q == LOST_LAST) begin
          state_d   = ST_SERVE;
          respawn_d = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (press) begin
          state_d   = ST_SERVE;
          lives_d   = LIVES_INIT;
          score_clr = 1'b1;
          respawn_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) frame_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      frame_cnt_q    <= '0;
      lives_q        <= LIVES_INIT;
      hit_f_q        <= 1'b0;
      lost_f_q       <= 1'b0;
      hit_prev_q     <= 1'b0;
      launch_prev_q  <= 1'b0;
      launch_armed_q <= 1'b0;
      motion_q       <= 1'b0;
      respawn_q      <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      lives_q       <= lives_d;
      launch_prev_q <= launchIsPressed;
      if (!launchIsPressed) launch_armed_q <= 1'b1;
      // Inputs on the frame-boundary cycle belong to the frame that is ending.
      if (startOfFrame) begin
        hit_f_q    <= 1'b0;
        lost_f_q   <= 1'b0;
        hit_prev_q <= hit_now;
      end else begin
        hit_f_q    <= hit_now;
        lost_f_q   <= lost_now;
      end
      motion_q    <= (state_d == ST_PLAY);
      respawn_q   <= respawn_d;
      game_over_q <= (state_d == ST_GAME_OVER);
    end
  end

  bcd_counter_2d u_score (
    .clk   (clk),
    .rst   (reset),
    .en_i  (score_inc),
    .clr_i (score_clr),
    .q_o   (scoreBcd)
  );

  assign gameState    = state_q;
  assign motionEnable = motion_q;
  assign ballRespawn  = respawn_q;
  assign livesLeft    = lives_q;
  assign gameOver     = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a phase-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_game_sequencer;

  localparam int LIVES = 3, SERVE_N = 60, LOST_N = 90;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame, collisionSmileyFlipper, ballLost, launchIsPressed;
  logic [2:0] gameState;
  logic       motionEnable, ballRespawn, gameOver;
  logic [7:0] scoreBcd;
  logic [1:0] livesLeft;

  int n_vec = 0, n_err = 0;

  game_sequencer #(.LIVES(LIVES), .SERVE_FRAMES(SERVE_N), .LOST_FRAMES(LOST_N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .startOfFrame           (startOfFrame),
    .collisionSmileyFlipper (collisionSmileyFlipper),
    .ballLost               (ballLost),
    .launchIsPressed        (launchIsPressed),
    .gameState              (gameState),
    .motionEnable           (motionEnable),
    .ballRespawn            (ballRespawn),
    .scoreBcd               (scoreBcd),
    .livesLeft              (livesLeft),
    .gameOver               (gameOver)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0..4, frames seen in phase, integer score.
  int m_phase, m_frames, m_score, m_lives;
  bit m_resp, key_down, hit_seen, lost_seen, prev_hit;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  always @(posedge clk or posedge reset) begin
    bit fh, fl, edge_k;
    if (reset) begin
      m_phase = 0; m_frames = 0; m_score = 0; m_lives = LIVES; m_resp = 0;
      key_down = 1; hit_seen = 0; lost_seen = 0; prev_hit = 0;
    end else begin
      fh = hit_seen || collisionSmileyFlipper;
      fl = lost_seen || ballLost;
      edge_k = launchIsPressed && !key_down;
      key_down = launchIsPressed;
      m_resp = 0;
      case (m_phase)
        0: begin
          m_score = 0; m_lives = LIVES;
          if (edge_k) begin m_phase = 1; m_frames = 0; m_resp = 1; end
        end
        1: if (startOfFrame) begin
          m_frames++;
          if (m_frames == SERVE_N) begin m_phase = 2; m_frames = 0; end
        end
        2: if (startOfFrame) begin
          if (fl) begin
            m_lives--;
            m_phase = (m_lives == 0) ? 4 : 3;
            m_frames = 0;
          end else if (fh && !prev_hit && m_score < 99) m_score++;
        end
        3: if (startOfFrame) begin
          m_frames++;
          if (m_frames == LOST_N) begin m_phase = 1; m_frames = 0; m_resp = 1; end
        end
        default: if (edge_k) begin
          m_phase = 1; m_frames = 0; m_score = 0; m_lives = LIVES; m_resp = 1;
        end
      endcase
      if (startOfFrame) begin
        prev_hit = fh; hit_seen = 0; lost_seen = 0;
      end else begin
        hit_seen = fh; lost_seen = fl;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_frame(input int len, input int lo, input int hi, input bit lost);
    for (int i = 0; i < len; i++) begin
      collisionSmileyFlipper = (i >= lo && i <= hi);
      ballLost               = lost && (i == len / 2);
      startOfFrame           = (i == len - 1);
      @(negedge clk);
    end
    collisionSmileyFlipper = 0; ballLost = 0; startOfFrame = 0;
  endtask

  task automatic idle_frames(input int n);
    for (int k = 0; k < n; k++) run_frame(4, 0, -1, 1'b0);
  endtask

  task automatic hit_gap();
    run_frame(4, 0, -1, 1'b0);
    run_frame(4, 3, 3, 1'b0);   // collision only on the boundary cycle
  endtask

  task automatic press_key();
    launchIsPressed = 1; @(negedge clk);
  endtask

  initial begin
    reset = 1;
    startOfFrame = 0; collisionSmileyFlipper = 0; ballLost = 0; launchIsPressed = 0;

    fork
      forever begin
        @(negedge clk);
        n_vec++;
        if (gameState !== 3'(m_phase) || motionEnable !== (m_phase == 2) ||
            ballRespawn !== m_resp || scoreBcd !== to_bcd(m_score) ||
            livesLeft !== 2'(m_lives) || gameOver !== (m_phase == 4)) begin
          n_err++;
          $display("FAIL cycle@%0t: st=%0d mot=%0b rsp=%0b sc=%h lv=%0d go=%0b, model st=%0d mot=%0b rsp=%0b sc=%h lv=%0d go=%0b",
                   $time, gameState, motionEnable, ballRespawn, scoreBcd, livesLeft, gameOver,
                   m_phase, m_phase == 2, m_resp, to_bcd(m_score), m_lives, m_phase == 4);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_state", gameState, 0);
    chk("reset_score", scoreBcd, 8'h00);
    chk("reset_lives", livesLeft, 3);

    // Serve: respawn one cycle after the press, PLAY after 60 frames.
    repeat (2) @(negedge clk);
    press_key();
    chk("press_respawn", ballRespawn, 1);
    chk("press_state", gameState, 1);
    launchIsPressed = 0;
    @(negedge clk);
    chk("respawn_one_cycle", ballRespawn, 0);
    idle_frames(SERVE_N - 1);
    chk("serve_59_motion", motionEnable, 0);
    idle_frames(1);
    chk("serve_60_motion", motionEnable, 1);
    chk("serve_60_state", gameState, 2);

    // Contact spanning three frames scores once; a fresh hit scores again.
    for (int k = 0; k < 3; k++) run_frame(24, 1, 20, 1'b0);
    chk("span_score", scoreBcd, 8'h01);
    run_frame(24, 0, -1, 1'b0);
    run_frame(24, 1, 20, 1'b0);
    chk("rehit_score", scoreBcd, 8'h02);

    // Units wrap and saturation.
    for (int k = 0; k < 7; k++) hit_gap();
    chk("score_09", scoreBcd, 8'h09);
    hit_gap();
    chk("score_10", scoreBcd, 8'h10);
    for (int k = 0; k < 89; k++) hit_gap();
    chk("score_99", scoreBcd, 8'h99);
    hit_gap();
    chk("score_sat", scoreBcd, 8'h99);

    // Lost and a new hit in one frame: lost wins, no score.
    run_frame(4, 0, -1, 1'b0);
    run_frame(24, 1, 20, 1'b1);
    chk("lost_lives", livesLeft, 2);
    chk("lost_state", gameState, 3);
    chk("lost_score", scoreBcd, 8'h99);
    chk("lost_motion", motionEnable, 0);
    idle_frames(LOST_N - 1);
    chk("lost_89_state", gameState, 3);
    idle_frames(1);
    chk("lost_90_state", gameState, 1);
    chk("lost_90_respawn", ballRespawn, 1);

    // Lose the remaining two balls.
    idle_frames(SERVE_N);
    run_frame(4, 0, -1, 1'b1);
    chk("second_lost_lives", livesLeft, 1);
    idle_frames(LOST_N + SERVE_N);
    run_frame(4, 0, -1, 1'b1);
    chk("gameover_state", gameState, 4);
    chk("gameover_flag", gameOver, 1);
    chk("gameover_lives", livesLeft, 0);
    repeat (10) @(negedge clk);
    chk("gameover_score_held", scoreBcd, 8'h99);

    // Press coincident with a frame pulse: press wins, serve count starts at 0.
    launchIsPressed = 1; startOfFrame = 1;
    @(negedge clk);
    startOfFrame = 0;
    chk("restart_state", gameState, 1);
    chk("restart_score", scoreBcd, 8'h00);
    chk("restart_lives", livesLeft, 3);
    chk("restart_respawn", ballRespawn, 1);
    launchIsPressed = 0;
    idle_frames(SERVE_N - 1);
    chk("restart_serve_59", gameState, 1);
    idle_frames(1);
    chk("restart_serve_60", gameState, 2);
    run_frame(24, 1, 20, 1'b0);
    chk("restart_hit", scoreBcd, 8'h01);

    // Asynchronous reset mid-play with the launch key held.
    launchIsPressed = 1;
    @(posedge clk); #2 reset = 1; #1;
    chk("async_state", gameState, 0);
    chk("async_motion", motionEnable, 0);
    chk("async_respawn", ballRespawn, 0);
    chk("async_score", scoreBcd, 8'h00);
    chk("async_lives", livesLeft, 3);
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    chk("held_key_state", gameState, 0);
    chk("held_key_respawn", ballRespawn, 0);
    launchIsPressed = 0;
    @(negedge clk);
    press_key();
    chk("new_edge_state", gameState, 1);
    chk("new_edge_respawn", ballRespawn, 1);
    launchIsPressed = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
